// File: rtl/parking_pkg.sv
// Shared constants and types for the parking controller input front-end.
package parking_pkg;
    localparam int DEBOUNCE_DEFAULT = 4;

    localparam int CH_ENTRY  = 0;
    localparam int CH_EXIT   = 1;
    localparam int CH_SWITCH = 2;

    typedef enum logic {ARB_IDLE, ARB_EXIT_PENDING} arb_state_e;
endpackage

// File: rtl/debounce_cell.sv
// Debounces a WIDTH-bit bus: the stable value only changes after DEBOUNCE_CYCLES
// consecutive identical samples that differ from it.
module debounce_cell #(
    parameter int WIDTH           = 1,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] stable_out
);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] last;

    // A multi-bit bus that hops between non-stable values must restart, so the
    // count always reflects a run of one identical candidate value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stable_out <= '0;
            cnt        <= '0;
            last       <= '0;
        end else begin
            last <= in;
            if (in == stable_out) begin
                cnt <= '0;
            end else if (cnt != '0 && in != last) begin
                cnt <= CNT_W'(1);
            end else if (cnt == LAST_CNT) begin
                stable_out <= in;
                cnt        <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/sensor_conditioner.sv
// Synchronises and debounces the raw parking sensors and slot switch, producing
// single-cycle entry/exit pulses that never coincide, plus a sticky overlap flag.
module sensor_conditioner
    import parking_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int CNT_W           = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       raw_entry,
    input  logic       raw_exit,
    input  logic [1:0] raw_switch,
    output logic       entry_sensor,
    output logic       exit_sensor,
    output logic [1:0] switch,
    output logic       overlap_err
);
    logic [3:0] raw_bus;
    logic [3:0] sync1;
    logic [3:0] sync2;
    logic       stable_entry;
    logic       stable_exit;
    logic [1:0] stable_switch;
    logic       prev_entry;
    logic       prev_exit;
    logic       rise_entry;
    logic       rise_exit;
    arb_state_e arb_state;

    always_comb begin
        raw_bus                          = '0;
        raw_bus[CH_ENTRY]                = raw_entry;
        raw_bus[CH_EXIT]                 = raw_exit;
        raw_bus[CH_SWITCH+1:CH_SWITCH]   = raw_switch;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw_bus;
            sync2 <= sync1;
        end
    end

    debounce_cell #(.WIDTH(1), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_entry (
        .clk(clk), .rst_n(rst_n), .in(sync2[CH_ENTRY]), .stable_out(stable_entry)
    );

    debounce_cell #(.WIDTH(1), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_exit (
        .clk(clk), .rst_n(rst_n), .in(sync2[CH_EXIT]), .stable_out(stable_exit)
    );

    debounce_cell #(.WIDTH(2), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_switch (
        .clk(clk), .rst_n(rst_n), .in(sync2[CH_SWITCH+1:CH_SWITCH]), .stable_out(stable_switch)
    );

    assign rise_entry = stable_entry & ~prev_entry;
    assign rise_exit  = stable_exit & ~prev_exit;

    // Entry always wins a tie; the exit is deferred by exactly one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_entry   <= 1'b0;
            prev_exit    <= 1'b0;
            entry_sensor <= 1'b0;
            exit_sensor  <= 1'b0;
            switch       <= '0;
            overlap_err  <= 1'b0;
            arb_state    <= ARB_IDLE;
        end else begin
            prev_entry   <= stable_entry;
            prev_exit    <= stable_exit;
            switch       <= stable_switch;
            overlap_err  <= overlap_err | (stable_entry & stable_exit);
            entry_sensor <= rise_entry;
            case (arb_state)
                ARB_IDLE: begin
                    exit_sensor <= rise_exit & ~rise_entry;
                    if (rise_exit && rise_entry) begin
                        arb_state <= ARB_EXIT_PENDING;
                    end
                end
                ARB_EXIT_PENDING: begin
                    if (rise_entry) begin
                        exit_sensor <= 1'b0;
                    end else begin
                        exit_sensor <= 1'b1;
                        arb_state   <= ARB_IDLE;
                    end
                end
                default: begin
                    exit_sensor <= 1'b0;
                    arb_state   <= ARB_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sensor_conditioner.sv
// Directed bench for sensor_conditioner with a sample-history reference model.
module tb_sensor_conditioner;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       raw_entry = 1'b0;
    logic       raw_exit = 1'b0;
    logic [1:0] raw_switch = 2'b00;
    logic       entry_sensor;
    logic       exit_sensor;
    logic [1:0] switch;
    logic       overlap_err;

    sensor_conditioner #(.DEBOUNCE_CYCLES(D), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .raw_entry(raw_entry), .raw_exit(raw_exit),
        .raw_switch(raw_switch), .entry_sensor(entry_sensor), .exit_sensor(exit_sensor),
        .switch(switch), .overlap_err(overlap_err)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;
    int edge_no = 0;
    bit started = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_no);
        end
    endtask

    // Reference model: raw values reach the debouncers two edges later; a channel
    // settles once its last D samples agree on a value other than the stable one.
    logic [3:0] m_s1 = '0, m_s2 = '0;
    int  hist_e[$], hist_x[$], hist_s[$];
    int  st_e = 0, st_x = 0, st_s = 0, pst_e = 0, pst_x = 0;
    int  evq[$];
    int  exp_entry = 0, exp_exit = 0, exp_sw = 0, exp_ovl = 0;

    function automatic int settle(input int h[$], input int cur);
        if (h.size() < D) return cur;
        for (int i = h.size() - D; i < h.size(); i++)
            if (h[i] != h[h.size()-1]) return cur;
        return h[h.size()-1];
    endfunction

    always @(posedge clk) begin
        int ev;
        logic [3:0] samp;
        edge_no++;
        started = 1'b1;
        if (!rst_n) begin
            m_s1 = '0; m_s2 = '0;
            hist_e.delete(); hist_x.delete(); hist_s.delete(); evq.delete();
            st_e = 0; st_x = 0; st_s = 0; pst_e = 0; pst_x = 0;
            exp_entry = 0; exp_exit = 0; exp_sw = 0; exp_ovl = 0;
        end else begin
            if (st_e == 1 && pst_e == 0) evq.push_back(0);
            if (st_x == 1 && pst_x == 0) evq.push_back(1);
            exp_entry = 0;
            exp_exit = 0;
            if (evq.size() > 0) begin
                ev = evq.pop_front();
                if (ev == 0) exp_entry = 1; else exp_exit = 1;
            end
            exp_sw = st_s;
            if (st_e == 1 && st_x == 1) exp_ovl = 1;
            pst_e = st_e;
            pst_x = st_x;
            samp = m_s2;
            hist_e.push_back(int'(samp[0]));
            hist_x.push_back(int'(samp[1]));
            hist_s.push_back(int'(samp[3:2]));
            while (hist_e.size() > D) void'(hist_e.pop_front());
            while (hist_x.size() > D) void'(hist_x.pop_front());
            while (hist_s.size() > D) void'(hist_s.pop_front());
            st_e = settle(hist_e, st_e);
            st_x = settle(hist_x, st_x);
            st_s = settle(hist_s, st_s);
            m_s2 = m_s1;
            m_s1 = {raw_switch, raw_exit, raw_entry};
        end
    end

    int n_entry = 0, n_exit = 0, both_seen = 0;
    int last_entry_edge = -1, last_exit_edge = -1;

    always @(negedge clk) begin
        if (started) begin
            check("cmp_entry", int'(entry_sensor), exp_entry);
            check("cmp_exit", int'(exit_sensor), exp_exit);
            check("cmp_switch", int'(switch), exp_sw);
            check("cmp_overlap", int'(overlap_err), exp_ovl);
            if (entry_sensor) begin n_entry++; last_entry_edge = edge_no; end
            if (exit_sensor) begin n_exit++; last_exit_edge = edge_no; end
            if (entry_sensor && exit_sensor) both_seen++;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        cycles(n);
        rst_n = 1'b1;
    endtask

    initial begin
        int base, e0, x0;
        // Reset held with every raw line active
        raw_entry = 1'b1; raw_exit = 1'b1; raw_switch = 2'b11;
        cycles(3);
        check("rst_entry", int'(entry_sensor), 0);
        check("rst_exit", int'(exit_sensor), 0);
        check("rst_switch", int'(switch), 0);
        check("rst_overlap", int'(overlap_err), 0);
        base = edge_no; e0 = n_entry;
        rst_n = 1'b1;
        cycles(12);
        check("rel_entry_edge", last_entry_edge - base, 7);
        check("rel_exit_edge", last_exit_edge - base, 8);
        check("rel_entry_count", n_entry - e0, 1);
        check("rel_switch", int'(switch), 3);
        raw_entry = 1'b0; raw_exit = 1'b0; raw_switch = 2'b00;
        cycles(12);
        check("rel_overlap_sticky", int'(overlap_err), 1);

        // Glitch rejection: 3-cycle pulse ignored, 4-cycle pulse accepted
        do_reset(2);
        check("glitch_overlap_cleared", int'(overlap_err), 0);
        e0 = n_entry;
        raw_entry = 1'b1; cycles(3); raw_entry = 1'b0; cycles(12);
        check("glitch_short", n_entry - e0, 0);
        raw_entry = 1'b1; cycles(4); raw_entry = 1'b0; cycles(12);
        check("glitch_exact", n_entry - e0, 1);

        // Simultaneous rise
        e0 = n_entry; x0 = n_exit; base = edge_no;
        raw_entry = 1'b1; raw_exit = 1'b1;
        cycles(12);
        check("sim_entry_edge", last_entry_edge - base, 7);
        check("sim_exit_edge", last_exit_edge - base, 8);
        check("sim_counts", (n_entry - e0) * 10 + (n_exit - x0), 11);
        check("sim_never_both", both_seen, 0);
        raw_entry = 1'b0; raw_exit = 1'b0;
        cycles(12);
        check("sim_overlap_sticky", int'(overlap_err), 1);

        // Reset while the deferred exit is pending
        do_reset(2);
        x0 = n_exit;
        raw_entry = 1'b1; raw_exit = 1'b1;
        cycles(7);
        check("pend_entry_now", int'(entry_sensor), 1);
        raw_entry = 1'b0; raw_exit = 1'b0;
        do_reset(2);
        cycles(15);
        check("pend_exit_dropped", n_exit - x0, 0);
        check("pend_overlap_cleared", int'(overlap_err), 0);

        // Switch bounce 00->10->00->10 then hold
        raw_switch = 2'b10; cycles(1);
        raw_switch = 2'b00; cycles(1);
        raw_switch = 2'b10; base = edge_no;
        cycles(6);
        check("sw_before_settle", int'(switch), 0);
        cycles(1);
        check("sw_settled_edge", edge_no - base, D + 3);
        check("sw_settled", int'(switch), 2);

        // Five clean entry presses
        e0 = n_entry; x0 = n_exit;
        for (int i = 0; i < 5; i++) begin
            raw_entry = 1'b1; cycles(10);
            raw_entry = 1'b0; cycles(10);
        end
        cycles(10);
        check("rep_entry_count", n_entry - e0, 5);
        check("rep_exit_count", n_exit - x0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/sensor_conditioner.md
Name: sensor_conditioner

Overview:
- Input front-end of the parking controller: sits directly upstream of the parking FSM top level.
- Takes raw, asynchronous entry/exit sensor lines and the 2-bit slot-select switch.
- Produces what the FSM top consumes: synchronised, debounced entry/exit single-cycle pulses (never both in one cycle) and a debounced switch value.
- Also reports a sticky flag when both sensors are held active together.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive synchronised samples that must differ from the stable value before it changes. Legal range 2..15.
- CNT_W, 4: width of each debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock, all logic on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- raw_entry  input  1  asynchronous entry sensor, active high.
- raw_exit  input  1  asynchronous exit sensor, active high.
- raw_switch  input  2  asynchronous slot-select switch.
- entry_sensor  output  1  one-cycle pulse per debounced entry rising edge.
- exit_sensor  output  1  one-cycle pulse per debounced exit rising edge.
- switch  output  2  debounced switch value, registered.
- overlap_err  output  1  sticky: both debounced sensors were high in the same cycle.

Behaviour:
- Reset (rst_n low at a clk edge):
  - All synchroniser flops, stable values, counters, the pending flag and all outputs go to 0.
  - Reset mid-debounce discards the partial count.
  - Reset with a deferred exit pending drops that exit.
- Synchroniser: two flops per raw bit (4 bits total). sync2 is the only value the debouncers see.
- Debounce cells: three independent channels (entry 1b, exit 1b, switch 2b treated as one bus).
  - If sync2 equals the channel's stable value, the counter clears to 0.
  - Otherwise the counter increments.
  - On the DEBOUNCE_CYCLES-th consecutive mismatching sample, stable loads sync2 and the counter clears.
  - For the switch bus, any change of sync2 value while counting restarts the count at 1.
- Latency: a raw level held from the clk edge that first samples it produces its effect on the output during the cycle after edge DEBOUNCE_CYCLES+3. With the default that is edge 7.
- Glitch rejection: pulses shorter than DEBOUNCE_CYCLES cycles at sync2 never change the stable value and produce no output.
- Pulse generation:
  - rise_entry / rise_exit = stable goes 0->1 this cycle.
  - Falling edges produce nothing.
- Arbitration (entry_sensor and exit_sensor are never both 1):
  - rise_entry alone: entry_sensor=1 next cycle.
  - rise_exit alone: exit_sensor=1 next cycle, unless an entry pulse is issuing that cycle; then it sets pending.
  - Both rise in the same cycle: entry_sensor=1 next cycle and exit_pending set.
  - exit_pending: exit_sensor=1 on the cycle after the entry pulse, then pending clears.
  - A new rise_exit cannot occur while pending is set, because DEBOUNCE_CYCLES>=2 guarantees this.
- switch output: registered copy of the switch stable value, same latency as the pulses.
- overlap_err: sets when entry stable and exit stable are both 1. Clears only on reset.

Decomposition:
- parking_pkg holds:
  - DEBOUNCE_DEFAULT=4.
  - Channel index constants CH_ENTRY=0, CH_EXIT=1, CH_SWITCH=2.
  - Enum arb_state_e {ARB_IDLE, ARB_EXIT_PENDING}.
- One sub-module, debounce_cell:
  - Parameters WIDTH and DEBOUNCE_CYCLES.
  - Ports clk, rst_n, in, stable_out.
  - Instantiated three times: WIDTH 1, 1, 2.
- Synchroniser, edge detect and arbiter stay in sensor_conditioner.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with all raw inputs 1 -> all outputs 0. After release, entry_sensor pulses once, at edge 7 after release, for exactly 1 cycle.
- Glitch: raw_entry high for 3 cycles then low (DEBOUNCE_CYCLES=4) -> no entry_sensor pulse. A 4-cycle pulse -> exactly one pulse.
- Simultaneous: raw_entry and raw_exit rise on the same edge, both held -> entry_sensor=1 at cycle 7, exit_sensor=1 at cycle 8, never both high. overlap_err=1 from cycle 7 and stays 1 after both drop.
- Switch bounce: raw_switch toggles 00->10->00->10 each cycle, then holds 10 -> switch stays 00 during bouncing and becomes 10 exactly DEBOUNCE_CYCLES+3 edges after the final change.
- Reset mid-operation: assert rst_n=0 with exit_pending set -> no exit_sensor pulse ever appears for that event. overlap_err returns to 0.
- Repeat: 5 clean entry presses, each held 10 and low 10 cycles -> exactly 5 entry_sensor pulses, 0 exit_sensor pulses.
